// File: rtl/fb_controller.sv
// Double-buffer framebuffer sequencer: clears the back buffer, hands the write
// port to the rasterizer, and swaps buffers on the first vsync after frame end.
module fb_controller #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter int          ADDR_W    = 17,
  parameter logic [11:0] CLEAR_RGB = 12'h000,
  parameter logic [7:0]  CLEAR_Z   = 8'hFF
) (
  input  logic              gpu_clk_in,
  input  logic              rst_in,
  input  logic              px_valid_in,
  output logic              px_ready_out,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [7:0]        z,
  input  logic [11:0]       rgb_in,
  input  logic              frame_done_in,
  input  logic              vsync_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [11:0]       wr_rgb_out,
  output logic [7:0]        wr_z_out,
  output logic              back_sel_out,
  output logic              frame_start_out,
  output logic              busy_out
);

  localparam int PIXELS = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {CLEAR, DRAW, WAIT_SWAP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              back_sel_reg, back_sel_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [11:0]       wr_rgb_reg, wr_rgb_next;
  logic [7:0]        wr_z_reg, wr_z_next;
  logic              ready_reg, ready_next;
  logic              frame_start_reg, frame_start_next;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] pixel_addr;

  assign accept     = px_valid_in && ready_reg;
  assign in_range   = (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
  assign pixel_addr = ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));

  always_comb begin
    state_next       = state_reg;
    clr_cnt_next     = clr_cnt_reg;
    back_sel_next    = back_sel_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_rgb_next      = wr_rgb_reg;
    wr_z_next        = wr_z_reg;
    ready_next       = 1'b0;
    frame_start_next = 1'b0;

    case (state_reg)
      CLEAR: begin
        wr_en_next   = 1'b1;
        wr_addr_next = clr_cnt_reg;
        wr_rgb_next  = CLEAR_RGB;
        wr_z_next    = CLEAR_Z;
        if (clr_cnt_reg == LAST_ADDR) begin
          clr_cnt_next = '0;
          state_next   = DRAW;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      DRAW: begin
        // ready is low only in the first DRAW cycle, which marks frame start
        ready_next       = !frame_done_in;
        frame_start_next = !ready_reg;
        if (accept && in_range) begin
          wr_en_next   = 1'b1;
          wr_addr_next = pixel_addr;
          wr_rgb_next  = rgb_in;
          wr_z_next    = z;
        end
        if (frame_done_in) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vsync_in) begin
          back_sel_next = !back_sel_reg;
          state_next    = CLEAR;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge gpu_clk_in) begin
    if (rst_in) begin
      state_reg       <= CLEAR;
      clr_cnt_reg     <= '0;
      back_sel_reg    <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_rgb_reg      <= '0;
      wr_z_reg        <= '0;
      ready_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_cnt_reg     <= clr_cnt_next;
      back_sel_reg    <= back_sel_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_rgb_reg      <= wr_rgb_next;
      wr_z_reg        <= wr_z_next;
      ready_reg       <= ready_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign px_ready_out    = ready_reg;
  assign wr_en_out       = wr_en_reg;
  assign wr_addr_out     = wr_addr_reg;
  assign wr_rgb_out      = wr_rgb_reg;
  assign wr_z_out        = wr_z_reg;
  assign back_sel_out    = back_sel_reg;
  assign frame_start_out = frame_start_reg;
  assign busy_out        = (state_reg != DRAW);

endmodule
